// File: rtl/shared_dff_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module      : shared_dff_arbiter_if
// Description : Requester/arbiter bundle for the shared register arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
interface shared_dff_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int OWNER_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         dout;
    logic [OWNER_W-1:0]       dout_owner;
    logic                     dout_upd;
    logic                     busy;

    modport master (
        output req, req_data,
        input  gnt, dout, dout_owner, dout_upd, busy
    );

    modport slave (
        input  req, req_data,
        output gnt, dout, dout_owner, dout_upd, busy
    );
endinterface
`default_nettype wire

// File: rtl/shared_dff_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : shared_dff_arbiter
// Description : Round-robin arbiter sharing one WIDTH-bit register among
//               NUM_REQ requesters, with a fixed hold-off after each grant.
// Revision    : 1.0 - initial release
// =============================================================================
module shared_dff_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    shared_dff_arbiter_if.slave bus
);
    localparam int OWNER_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [OWNER_W:0]   c_num_req  = (OWNER_W+1)'(NUM_REQ);
    localparam logic [OWNER_W-1:0] c_last_idx = OWNER_W'(NUM_REQ - 1);
    localparam logic [7:0]         c_hold     = 8'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [OWNER_W-1:0]   ptr_q,   ptr_d;
    logic [7:0]           cnt_q,   cnt_d;
    logic [NUM_REQ-1:0]   gnt_q,   gnt_d;
    logic [WIDTH-1:0]     dout_q,  dout_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic                 upd_q,   upd_d;
    logic                 busy_q,  busy_d;

    logic [OWNER_W:0]     w_idx;
    logic [OWNER_W-1:0]   w_win;
    logic                 w_found;

    // Circular search starting at ptr; the extra index bit absorbs ptr+i
    // before it is folded back into 0..NUM_REQ-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, ptr_q} + (OWNER_W+1)'(i);
            if (w_idx >= c_num_req) begin
                w_idx = w_idx - c_num_req;
            end
            if (!w_found && bus.req[w_idx[OWNER_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[OWNER_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        upd_d   = 1'b0;
        dout_d  = dout_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (w_found) begin
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
                    dout_d  = bus.req_data[w_win*WIDTH +: WIDTH];
                    owner_d = w_win;
                    upd_d   = 1'b1;
                    ptr_d   = (w_win == c_last_idx) ? '0 : w_win + 1'b1;
                    cnt_d   = c_hold;
                    busy_d  = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (c_hold != 8'd0) begin
                    busy_d  = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            dout_q  <= '0;
            owner_q <= '0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            dout_q  <= dout_d;
            owner_q <= owner_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.dout       = dout_q;
    assign bus.dout_owner = owner_q;
    assign bus.dout_upd   = upd_q;
    assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_dff_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_shared_dff_arbiter
// Description : Scoreboard bench for shared_dff_arbiter (HOLD=2 and HOLD=0).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_shared_dff_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] dout;
        logic [1:0] owner;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    shared_dff_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus_a ();
    shared_dff_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus_b ();

    shared_dff_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .HOLD_CYCLES(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    shared_dff_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .HOLD_CYCLES(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_a(input logic [3:0] g, input logic [7:0] d, input logic [1:0] o, input int c);
        exp_t e;
        e.gnt = g; e.dout = d; e.owner = o; e.cyc = c;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [3:0] g, input logic [7:0] d, input logic [1:0] o, input int c);
        exp_t e;
        e.gnt = g; e.dout = d; e.owner = o; e.cyc = c;
        qb.push_back(e);
    endtask

    task automatic set_a(input int i, input logic [7:0] v);
        bus_a.req_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic set_b(input int i, input logic [7:0] v);
        bus_b.req_data[i*WIDTH +: WIDTH] = v;
    endtask

    // Single grant on A, then asynchronous reset one cycle into HOLD.
    task automatic grant_then_reset(input int idx, input logic [7:0] v, input string tag);
        set_a(idx, v);
        bus_a.req = 4'(1 << idx);
        push_a(4'(1 << idx), v, 2'(idx), cyc + 1);
        @(negedge clk);
        bus_a.req = '0;
        @(negedge clk);
        chk({tag, "_busy_in_hold"}, 32'(bus_a.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk({tag, "_rst_gnt"},   32'(bus_a.gnt),        32'd0);
        chk({tag, "_rst_dout"},  32'(bus_a.dout),       32'd0);
        chk({tag, "_rst_owner"}, 32'(bus_a.dout_owner), 32'd0);
        chk({tag, "_rst_upd"},   32'(bus_a.dout_upd),   32'd0);
        chk({tag, "_rst_busy"},  32'(bus_a.busy),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin : mon_a
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus_a.dout_upd || (bus_a.gnt != '0)) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_grant gnt=%b dout=%h cyc=%0d expected no grant",
                             bus_a.gnt, bus_a.dout, cyc);
                end else begin
                    e = qa.pop_front();
                    chk("a_gnt",   32'(bus_a.gnt),        32'(e.gnt));
                    chk("a_dout",  32'(bus_a.dout),       32'(e.dout));
                    chk("a_owner", 32'(bus_a.dout_owner), 32'(e.owner));
                    chk("a_upd",   32'(bus_a.dout_upd),   32'd1);
                    chk("a_cycle", 32'(cyc),              32'(e.cyc));
                end
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus_b.dout_upd || (bus_b.gnt != '0)) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_grant gnt=%b dout=%h cyc=%0d expected no grant",
                             bus_b.gnt, bus_b.dout, cyc);
                end else begin
                    e = qb.pop_front();
                    chk("b_gnt",   32'(bus_b.gnt),        32'(e.gnt));
                    chk("b_dout",  32'(bus_b.dout),       32'(e.dout));
                    chk("b_owner", 32'(bus_b.dout_owner), 32'(e.owner));
                    chk("b_upd",   32'(bus_b.dout_upd),   32'd1);
                    chk("b_cycle", 32'(cyc),              32'(e.cyc));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int         c;
        int         busy_cnt;
        int         bad;
        logic [7:0] pat;

        bus_a.req = '0; bus_a.req_data = '0;
        bus_b.req = '0; bus_b.req_data = '0;
        repeat (3) @(negedge clk);

        chk("rst_gnt",   32'(bus_a.gnt),        32'd0);
        chk("rst_dout",  32'(bus_a.dout),       32'd0);
        chk("rst_owner", 32'(bus_a.dout_owner), 32'd0);
        chk("rst_upd",   32'(bus_a.dout_upd),   32'd0);
        chk("rst_busy",  32'(bus_a.busy),       32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 2
        set_a(2, 8'hA5);
        bus_a.req = 4'b0100;
        push_a(4'b0100, 8'hA5, 2'd2, cyc + 1);
        busy_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) bus_a.req = '0;
            if (bus_a.busy) busy_cnt++;
            if (k == 2) begin
                chk("t1_upd_pulse", 32'(bus_a.dout_upd), 32'd0);
                chk("t1_dout_hold", 32'(bus_a.dout),     32'hA5);
            end
        end
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd3);

        // All four requesting, starting from a fresh pointer
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_a(i, 8'(16 + i));
        bus_a.req = 4'b1111;
        c = cyc;
        for (int k = 0; k < 5; k++)
            push_a(4'(1 << (k % 4)), 8'(16 + (k % 4)), 2'(k % 4), c + 1 + 4 * k);
        repeat (17) @(negedge clk);
        bus_a.req = '0;
        repeat (6) @(negedge clk);

        // Pointer wrap and skip
        set_a(1, 8'h21);
        set_a(3, 8'h33);
        bus_a.req = 4'b1000;
        c = cyc;
        push_a(4'b1000, 8'h33, 2'd3, c + 1);
        push_a(4'b0010, 8'h21, 2'd1, c + 5);
        push_a(4'b1000, 8'h33, 2'd3, c + 9);
        push_a(4'b0010, 8'h21, 2'd1, c + 13);
        @(negedge clk);
        bus_a.req = 4'b1010;
        repeat (12) @(negedge clk);
        bus_a.req = '0;
        repeat (6) @(negedge clk);

        // Zero hold-off on the second instance
        set_b(0, 8'h40);
        set_b(1, 8'h41);
        bus_b.req = 4'b0011;
        c = cyc;
        push_b(4'b0001, 8'h40, 2'd0, c + 1);
        push_b(4'b0010, 8'h41, 2'd1, c + 3);
        push_b(4'b0001, 8'h40, 2'd0, c + 5);
        push_b(4'b0010, 8'h41, 2'd1, c + 7);
        pat = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 7) bus_b.req = '0;
            pat[k-1] = bus_b.busy;
        end
        chk("t4_busy_pattern", 32'(pat), 32'h55);
        repeat (4) @(negedge clk);

        // Reset mid-HOLD, then arbitration restarts from requester 0
        grant_then_reset(0, 8'h55, "t5a");
        chk("t5_rst_b_dout", 32'(bus_b.dout), 32'd0);
        set_a(3, 8'h77);
        bus_a.req = 4'b1000;
        push_a(4'b1000, 8'h77, 2'd3, cyc + 1);
        @(negedge clk);
        bus_a.req = '0;
        repeat (5) @(negedge clk);
        grant_then_reset(1, 8'h21, "t5b");
        set_a(0, 8'h66);
        bus_a.req = 4'b1001;
        c = cyc;
        push_a(4'b0001, 8'h66, 2'd0, c + 1);
        push_a(4'b1000, 8'h77, 2'd3, c + 5);
        @(negedge clk);
        bus_a.req = 4'b1000;
        repeat (4) @(negedge clk);
        bus_a.req = '0;
        repeat (6) @(negedge clk);

        // Request that exists only while the arbiter is in HOLD
        set_a(2, 8'h99);
        bus_a.req = 4'b0100;
        push_a(4'b0100, 8'h99, 2'd2, cyc + 1);
        @(negedge clk);
        bus_a.req = '0;
        @(negedge clk);
        bus_a.req = 4'b0010;
        repeat (2) @(negedge clk);
        bus_a.req = '0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if ((bus_a.gnt != '0) || bus_a.dout_upd || (bus_a.dout != 8'h99)) bad++;
        end
        chk("t6_pulse_ignored", 32'(bad),        32'd0);
        chk("t6_dout_kept",     32'(bus_a.dout), 32'h99);

        repeat (5) @(negedge clk);
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
